lvds_rx_framer: RTL
===================

# lvds_rx_framer

Frames the AT86RF215 LVDS I/Q receive stream into 32-bit sample words and pushes them into the per-band RX FIFO that the SMI controller drains toward the Raspberry Pi. Each band uses one instance, fed by the DDR input cell (2 bits per clock). The block hunts for I/Q sync, tracks lock, and writes one word per 16 clocks. It reports FIFO overflow and sync loss.

## Interface
- `LOCK_THRESHOLD`, default 2: the number of consecutive well-framed words required before pushing begins (range 1..15).
- `i_sys_clk`  in  1  Sampling clock; DDR pair rate.
- `i_reset_n`  in  1  Reset; asynchronous, active-low.
- `i_enable`  in  1  Framer run enable. Low forces the HUNT state.
- `i_ddr_data`  in  2  One DDR pair per clock; bit[1] is earlier in time.
- `i_fifo_full`  in  1  Target FIFO full.
- `i_clear_errors`  in  1  Single-cycle pulse that clears the sticky flags and the drop count.
- `o_fifo_push`  out  1  One-cycle write strobe.
- `o_fifo_write_data`  out  32  Framed word; valid while `o_fifo_push` is high.
- `o_locked`  out  1  Lock status.
- `o_sync_error`  out  1  Sticky flag: sync was lost after lock.
- `o_overflow`  out  1  Sticky flag: a word was dropped because the FIFO was full.
- `o_drop_count`  out  8  Count of dropped words; saturates at 255.

## Operation
- **Word format (MSB first in time):**
  - [31:30] = I_SYNC 2'b10
  - [29:17] = I[12:0]
  - [16] = I control
  - [15:14] = Q_SYNC 2'b01
  - [13:1] = Q[12:0]
  - [0] = Q control
- The SMI side sends this word MSB byte first, so the word is pushed unmodified.
- **States:** HUNT, FRAME.
- **HUNT:**
  - `pair_idx` = 0 and `good_cnt` = 0; `o_locked` = 0.
  - A pair of 2'b10 while `i_enable`=1 moves to FRAME, loads the shift register with 2'b10, and sets `pair_idx` = 1.
- **FRAME:**
  - Each clock shifts in one pair; `pair_idx` (4-bit) increments and wraps 15→0.
  - At `pair_idx` 8, a pair other than 2'b01 is a sync failure.
  - At `pair_idx` 0 (the start of the next word), a pair other than 2'b10 is a sync failure.
  - When pair 15 is captured, the word is complete:
    - If `good_cnt` < LOCK_THRESHOLD: increment `good_cnt`, do not push. When the count reaches LOCK_THRESHOLD, set `o_locked` on the same edge.
    - If locked and `i_fifo_full`=0: push the word.
    - If locked and `i_fifo_full`=1: drop the word, set `o_overflow`, increment `o_drop_count` (saturating).
- **Sync failure:**
  - Return to HUNT and discard the partial word.
  - If `o_locked` was 1, set `o_sync_error`.
  - Clear `o_locked` and `good_cnt`.
- **Resync on the same cycle:** if the failing pair is 2'b10 at `pair_idx` 8, the block re-enters HUNT first. It does not resync on that same cycle; the next 2'b10 pair is required.
- **`i_enable` falling mid-frame:** go to HUNT next cycle and discard the partial word. This does not set `o_sync_error`. Sticky flags hold.
- **`i_clear_errors` on the same edge as a new error:** the set wins.
- **`i_clear_errors`** zeroes `o_drop_count`; a drop on the same edge leaves the count at 1.

## Timing
- Registered outputs; no combinational input-to-output paths.
- **Push latency:** pair 15 is sampled on edge N; `o_fifo_push` and data are high for exactly edge N+1 to N+2.
- **Throughput:** at most one push per 16 clocks, so there are never back-to-back pushes.
- `i_fifo_full` is sampled on edge N (the completion edge).
- **Lock timing:** the first push occurs after 16·LOCK_THRESHOLD + 16 pairs from the first sync. With the default, that is word 3.
- **Reset values (asynchronous assert, synchronous-safe release):**
  - state = HUNT
  - `o_fifo_push`=0, `o_fifo_write_data`=0
  - `o_locked`=0, `o_sync_error`=0, `o_overflow`=0
  - `o_drop_count`=0
- Reset asserted mid-frame aborts the frame immediately; no push escapes.

## Structure
- **Shared package `lvds_rx_pkg`:**
  - constants I_SYNC=2'b10 and Q_SYNC=2'b01
  - state enum {HUNT, FRAME}
  - word field positions
- **Single module;** no sub-module is warranted. The saturating counter is inline.
- The SMI controller's FIFO status bits consume the same FIFO flags; no changes are needed there.

## Test plan
- **Clean stream:** word 0xA5B2_5A4D repeated continuously (valid syncs). Required response:
  - `o_locked` rises at the end of word 2.
  - The first push carries 0xA5B2_5A4D at word 3, and every 16 clocks after that.
  - The error flags stay 0.
- **Q sync corrupted:** after lock, pair 8 of one word is 2'b11. Required response:
  - `o_sync_error`=1 and `o_locked`=0; no push for that word.
  - Relock and the next push occur 3 words after the next valid I_SYNC.
- **FIFO full:** `i_fifo_full`=1 for 3 consecutive completion edges while locked. Required response: no push, `o_overflow`=1, `o_drop_count`=3. Then `i_clear_errors` returns both to 0.
- **Drop saturation:** 300 drops give `o_drop_count`=255. `i_clear_errors` coincident with a drop gives 1.
- **Enable drop:** `i_enable` falls at `pair_idx` 5 while locked. Required response:
  - No push; HUNT entered.
  - `o_sync_error` stays 0 and `o_locked`=0.
- **Reset:** `i_reset_n` pulsed low at `pair_idx` 15. Required response: no push on the next edge, and all outputs are at their reset values.

Source files
------------

// File: rtl/lvds_rx_pkg.sv
// Shared constants and types for the AT86RF215 LVDS I/Q receive framer.
package lvds_rx_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PAIR_W = 2;

    localparam logic [1:0] I_SYNC = 2'b10;
    localparam logic [1:0] Q_SYNC = 2'b01;

    // Bit positions of the two sync fields inside a framed word.
    localparam int unsigned I_SYNC_LSB = 30;
    localparam int unsigned Q_SYNC_LSB = 14;

    // Pair slots (0 = earliest in time) that carry each sync field.
    localparam logic [3:0] I_SYNC_PAIR = 4'((WORD_W - PAIR_W - I_SYNC_LSB) / PAIR_W);
    localparam logic [3:0] Q_SYNC_PAIR = 4'((WORD_W - PAIR_W - Q_SYNC_LSB) / PAIR_W);
    localparam logic [3:0] LAST_PAIR   = 4'(WORD_W / PAIR_W - 1);

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0]  i_sync;
        logic [12:0] i_data;
        logic        i_ctrl;
        logic [1:0]  q_sync;
        logic [12:0] q_data;
        logic        q_ctrl;
    } sample_word_t;

endpackage

// File: rtl/lvds_rx_framer.sv
// Frames the DDR I/Q pair stream into 32-bit sample words for the per-band RX FIFO,
// tracking sync and lock and reporting FIFO overflow and sync loss.
module lvds_rx_framer
    import lvds_rx_pkg::*;
#(
    parameter int unsigned LOCK_THRESHOLD = 2
) (
    input  logic        i_sys_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic [1:0]  i_ddr_data,
    input  logic        i_fifo_full,
    input  logic        i_clear_errors,
    output logic        o_fifo_push,
    output logic [31:0] o_fifo_write_data,
    output logic        o_locked,
    output logic        o_sync_error,
    output logic        o_overflow,
    output logic [7:0]  o_drop_count
);

    localparam logic [3:0]  LOCK_CNT = 4'(LOCK_THRESHOLD);
    localparam int unsigned SHIFT_W  = WORD_W - PAIR_W;

    state_e             state_q,    state_d;
    logic [3:0]         pair_idx_q, pair_idx_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic [SHIFT_W-1:0] shift_q,    shift_d;
    logic               locked_q,   locked_d;
    logic               pend_q,     pend_d;
    logic               push_q,     push_d;
    sample_word_t       wdata_q,    wdata_d;
    logic               sync_err_q, sync_err_d;
    logic               ovf_q,      ovf_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic               sync_fail;

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!i_reset_n) begin
            state_q    <= HUNT;
            pair_idx_q <= '0;
            good_cnt_q <= '0;
            shift_q    <= '0;
            locked_q   <= 1'b0;
            pend_q     <= 1'b0;
            push_q     <= 1'b0;
            wdata_q    <= '0;
            sync_err_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pair_idx_q <= pair_idx_d;
            good_cnt_q <= good_cnt_d;
            shift_q    <= shift_d;
            locked_q   <= locked_d;
            pend_q     <= pend_d;
            push_q     <= push_d;
            wdata_q    <= wdata_d;
            sync_err_q <= sync_err_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d    = state_q;
        pair_idx_d = pair_idx_q;
        good_cnt_d = good_cnt_q;
        shift_d    = shift_q;
        locked_d   = locked_q;
        pend_d     = 1'b0;
        push_d     = pend_q;
        wdata_d    = wdata_q;
        sync_err_d = sync_err_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        sync_fail  = 1'b0;

        // Clear is applied first so a same-edge error below overrides it.
        if (i_clear_errors) begin
            sync_err_d = 1'b0;
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end

        case (state_q)
            HUNT: begin
                pair_idx_d = '0;
                good_cnt_d = '0;
                locked_d   = 1'b0;
                if (i_enable && i_ddr_data == I_SYNC) begin
                    state_d    = FRAME;
                    shift_d    = SHIFT_W'(I_SYNC);
                    pair_idx_d = 4'd1;
                end
            end
            FRAME: begin
                sync_fail = (pair_idx_q == Q_SYNC_PAIR && i_ddr_data != Q_SYNC) ||
                            (pair_idx_q == I_SYNC_PAIR && i_ddr_data != I_SYNC);
                if (!i_enable || sync_fail) begin
                    state_d    = HUNT;
                    pair_idx_d = '0;
                    good_cnt_d = '0;
                    locked_d   = 1'b0;
                    if (i_enable && locked_q) begin
                        sync_err_d = 1'b1;
                    end
                end else begin
                    shift_d    = {shift_q[SHIFT_W-PAIR_W-1:0], i_ddr_data};
                    pair_idx_d = pair_idx_q + 4'd1;
                    if (pair_idx_q == LAST_PAIR) begin
                        if (good_cnt_q < LOCK_CNT) begin
                            good_cnt_d = good_cnt_q + 4'd1;
                            locked_d   = (good_cnt_d == LOCK_CNT);
                        end else if (!i_fifo_full) begin
                            // Push is staged one cycle so the strobe follows the completion edge.
                            pend_d  = 1'b1;
                            wdata_d = sample_word_t'({shift_q, i_ddr_data});
                        end else begin
                            ovf_d = 1'b1;
                            if (i_clear_errors) begin
                                drop_cnt_d = 8'd1;
                            end else if (drop_cnt_q != 8'hFF) begin
                                drop_cnt_d = drop_cnt_q + 8'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign o_fifo_push       = push_q;
    assign o_fifo_write_data = wdata_q;
    assign o_locked          = locked_q;
    assign o_sync_error      = sync_err_q;
    assign o_overflow        = ovf_q;
    assign o_drop_count      = drop_cnt_q;

endmodule
